// File: rtl/s_u_bam_iter_mult.sv
// Sequential unsigned broken-array multiplier: one partial-product row per clock,
// with a per-operation choice between the broken (approximate) term set and the exact product.
module s_u_bam_iter_mult #(
  parameter int N     = 8,
  parameter int H_CUT = 2,
  parameter int V_CUT = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           approx_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] prod
);

  localparam int RW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic           mode_r;
  logic [RW-1:0]  row;
  logic [2*N-1:0] acc;

  logic           accept;
  logic           row_last;
  logic           row_bit;
  logic [N-1:0]   row_mask;
  logic [2*N-1:0] row_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE can hand off its result and take a new pair in the same cycle, so a
  // stream of operations runs with no idle bubble between them.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (row_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign row_last = (row == RW'(N - 1));
  assign row_bit  = |(b_r & (N'(1) << row));

  // Vertical break: column i of the current row survives only when its weight
  // i+row reaches V_CUT; exact mode keeps every column.
  always_comb begin
    row_mask = '0;
    for (int i = 0; i < N; i++) begin
      row_mask[i] = !mode_r || ((i + int'(row)) >= V_CUT);
    end
  end

  assign row_term = {{N{1'b0}}, a_r & row_mask} << row;

  // The horizontal break is applied by starting the row counter at H_CUT, so
  // broken rows never cost a cycle while masked rows still do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= 1'b0;
      row    <= '0;
      acc    <= '0;
    end else if (accept) begin
      a_r    <= a;
      b_r    <= b;
      mode_r <= approx_en;
      acc    <= '0;
      row    <= approx_en ? RW'(H_CUT) : '0;
    end else if (state == BUSY) begin
      if (row_bit) acc <= acc + row_term;
      row <= row + RW'(1);
    end
  end

  assign prod = acc;

endmodule

// File: tb/tb_s_u_bam_iter_mult.sv
// Bench for s_u_bam_iter_mult: directed corner cases plus a randomized stream
// checked against a term-by-term model of the kept partial products.
module tb_s_u_bam_iter_mult;

  localparam int N     = 8;
  localparam int H_CUT = 2;
  localparam int V_CUT = 12;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a         = '0;
  logic [N-1:0]   b         = '0;
  logic           approx_en = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] prod;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [2*N-1:0] p;
    int             acc_cycle;
    int             r;
  } exp_t;

  exp_t exp_q[$];

  s_u_bam_iter_mult #(.N(N), .H_CUT(H_CUT), .V_CUT(V_CUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 clk = ~clk;

  // Sum of every surviving a[i]*b[j] term, weighted 2^(i+j).
  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] x, input logic [N-1:0] y,
                                               input logic mode);
    logic [2*N-1:0] s;
    logic [2*N-1:0] one;
    s   = '0;
    one = 1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (x[i] && y[j] && (!mode || (j >= H_CUT && i + j >= V_CUT)))
          s = s + (one << (i + j));
    return s;
  endfunction

  function automatic int ref_lat(input logic mode);
    return mode ? N - H_CUT : N;
  endfunction

  // Presents one pair (also taking any pending result), then counts edges
  // until out_valid; operands and mode are scrambled after acceptance.
  task automatic do_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ie,
                       output logic rdy, output int lat, output logic [2*N-1:0] p);
    a = ia; b = ib; approx_en = ie; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    rdy = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    a = ~ia; b = ~ib; approx_en = ~ie;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    p = prod;
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (prod !== '0) $display("[TB] FAIL reset_prod: got %0d expected 0", prod); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL post_reset_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_directed;
    int          ta [5] = '{255, 255, 240, 240, 255};
    int          tb [5] = '{255, 255, 240, 240, 3};
    int          tm [5] = '{1, 0, 1, 0, 1};
    int          tp [5] = '{45056, 65025, 45056, 57600, 0};
    int          tl [5] = '{6, 8, 6, 8, 6};
    logic        rdy;
    int          lat;
    logic [15:0] p;
    for (int k = 0; k < 5; k++) begin
      do_op(8'(ta[k]), 8'(tb[k]), 1'(tm[k]), rdy, lat, p);
      checks++; if (rdy !== 1'b1) $display("[TB] FAIL directed%0d_ready: got %b expected 1", k, rdy); else passed++;
      checks++; if (lat !== tl[k]) $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", k, lat, tl[k]); else passed++;
      checks++; if (p !== 16'(tp[k])) $display("[TB] FAIL directed%0d_prod: got %0d expected %0d", k, p, tp[k]); else passed++;
      release_result();
    end
  endtask

  task automatic test_back_to_back;
    logic        rdy;
    int          lat;
    logic [15:0] p;
    do_op(8'hFF, 8'hFF, 1'b1, rdy, lat, p);
    checks++; if (lat !== 6) $display("[TB] FAIL bp_first_latency: got %0d expected 6", lat); else passed++;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid: got %b expected 1", out_valid); else passed++;
      checks++; if (prod !== 16'hB000) $display("[TB] FAIL bp_hold_prod: got %0d expected 45056", prod); else passed++;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_hold_in_ready: got %b expected 0", in_ready); else passed++;
    end
    do_op(8'hF0, 8'hF0, 1'b1, rdy, lat, p);
    checks++; if (rdy !== 1'b1) $display("[TB] FAIL b2b_ready: got %b expected 1", rdy); else passed++;
    checks++; if (lat !== 6) $display("[TB] FAIL b2b_latency: got %0d expected 6", lat); else passed++;
    checks++; if (p !== 16'd45056) $display("[TB] FAIL b2b_prod: got %0d expected 45056", p); else passed++;
    release_result();
  endtask

  task automatic test_reset_mid_busy;
    logic        rdy;
    int          lat;
    logic [15:0] p;
    a = 8'hFF; b = 8'hFF; approx_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (prod !== '0) $display("[TB] FAIL midrst_prod: got %0d expected 0", prod); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(8'h03, 8'h05, 1'b0, rdy, lat, p);
    checks++; if (lat !== 8) $display("[TB] FAIL midrst_next_latency: got %0d expected 8", lat); else passed++;
    checks++; if (p !== 16'd15) $display("[TB] FAIL midrst_next_prod: got %0d expected 15", p); else passed++;
    release_result();
  endtask

  task automatic test_random_stream;
    int          sent    = 0;
    int          got     = 0;
    int          cyc     = 0;
    bit          holding = 0;
    bit          held    = 0;
    logic [15:0] prev_p  = '0;
    exp_t        e;
    while ((sent < 1000 || got < sent) && cyc < 60000) begin
      if (!holding && sent < 1000 && $urandom_range(0, 3) != 0) begin
        a = N'($urandom); b = N'($urandom); approx_en = 1'($urandom);
        in_valid = 1'b1; holding = 1;
      end
      if (!holding) begin
        in_valid = 1'b0; approx_en = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid) begin
        if (held) begin
          checks++; if (prod !== prev_p) $display("[TB] FAIL rnd_stable: got %0d expected %0d", prod, prev_p); else passed++;
        end
        checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL rnd_extra_result: got result %0d expected none", prod);
        end else begin
          passed++;
          if (!held) begin
            checks++;
            if (cyc - exp_q[0].acc_cycle - 1 !== exp_q[0].r)
              $display("[TB] FAIL rnd_latency: got %0d expected %0d", cyc - exp_q[0].acc_cycle - 1, exp_q[0].r);
            else passed++;
          end
          if (out_ready) begin
            e = exp_q.pop_front();
            got++;
            checks++; if (prod !== e.p) $display("[TB] FAIL rnd_prod: got %0d expected %0d", prod, e.p); else passed++;
          end
        end
      end
      held   = out_valid && !out_ready;
      prev_p = prod;
      if (in_valid && in_ready) begin
        e.p = ref_prod(a, b, approx_en); e.acc_cycle = cyc; e.r = ref_lat(approx_en);
        exp_q.push_back(e);
        sent++; holding = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got !== 1000) $display("[TB] FAIL rnd_result_count: got %0d expected 1000", got); else passed++;
    checks++; if (exp_q.size() !== 0) $display("[TB] FAIL rnd_leftover: got %0d expected 0", exp_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_busy();
    test_random_stream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/s_u_bam_iter_mult.md
# s_u_bam_iter_mult

Sequential, parametrised unsigned broken-array multiplier (BAM). It is the clocked successor of the combinational fixed-width BAM blocks. It computes the sum of the partial-product terms a[i]·b[j] that survive the horizontal/vertical break, one partial-product row per clock. A runtime mode bit selects exact multiplication instead. It sits behind a valid/ready stream in datapaths that trade accuracy and area for a multi-cycle latency.

## Interface
Parameters:
- N, default 8: operand width in bits; N ≥ 2.
- H_CUT, default 2: rows j < H_CUT are broken (omitted) in approximate mode; 0 ≤ H_CUT < N.
- V_CUT, default 12: terms with i+j < V_CUT are broken in approximate mode; 0 ≤ V_CUT ≤ 2N-2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair a, b and approx_en are valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- a  in  N  multiplicand, unsigned.
- b  in  N  multiplier, unsigned.
- approx_en  in  1  1 = BAM approximate mode, 0 = exact product.
- out_valid  out  1  prod holds a finished result.
- out_ready  in  1  consumer takes the result this cycle.
- prod  out  2N  result, unsigned, full width with no truncated carry.

## Operation
- Kept term set:
  - Approximate mode: term a[i]·b[j] is kept iff j ≥ H_CUT and i+j ≥ V_CUT.
  - Exact mode: all terms are kept.
- prod is the exact 2N-bit sum of the kept terms, each weighted 2^(i+j). No carry is dropped, including into bit 2N-1.
- Registers:
  - A_r (N bits) and B_r (N bits).
  - mode_r, which holds approx_en as captured at acceptance.
  - Row counter row (⌈log2 N⌉+1 bits).
  - Accumulator acc (2N bits).
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid: capture a, b, approx_en; acc←0; row←(approx_en ? H_CUT : 0); go to BUSY.
  - BUSY:
    - in_ready=0.
    - Each cycle: acc ← acc + ((A_r & M_row) << row) if B_r[row]=1, else acc unchanged; then row←row+1.
    - M_row bit i is 1 iff mode_r=0 or i+row ≥ V_CUT.
    - When the row just processed is N-1, go to DONE.
  - DONE:
    - out_valid=1 and prod=acc.
    - in_ready=out_ready.
    - On out_ready with in_valid: accept the new operands (as in IDLE) and go directly to BUSY.
    - On out_ready without in_valid: go to IDLE.
    - Otherwise hold.
- Rows processed per operation: R = N-H_CUT in approximate mode, R = N in exact mode.
- Masked rows still consume their cycle; the latency depends on the mode only, never on the data.
- approx_en is ignored outside acceptance. A mode change never affects an operation in flight.

## Timing
- Reset (asynchronous assert, any state):
  - state=IDLE, in_ready=1, out_valid=0, prod=0, acc=0, row=0, A_r=B_r=0, mode_r=0.
  - An operation in flight is discarded and no result is emitted.
  - Release is synchronous to clk; the first acceptance can occur on the first rising edge with rst_n=1.
- Acceptance at edge k: out_valid rises after edge k+R.
  - Approximate default (N=8, H_CUT=2): R = 6.
  - Exact (N=8): R = 8.
- prod is updated only in BUSY. It is stable, and equal to the result, for every cycle that out_valid=1.
- Back-pressure: out_valid stays 1 and prod is held until out_ready=1.
- Sustained throughput is one result per R+1 cycles with zero bubbles, because DONE accepts a new pair in the same cycle the result leaves.
- in_valid while BUSY: the pair is not accepted (in_ready=0), and the producer must hold it.
- Degenerate case H_CUT=0, V_CUT=0 in approximate mode: exact behaviour and latency N.

## Test plan
- Reset, then a=0xFF, b=0xFF, approx_en=1 (N=8, H=2, V=12) → out_valid 6 cycles after acceptance, prod=45056 (0xB000).
- Same operands with approx_en=0 → out_valid 8 cycles after acceptance, prod=65025 (0xFE01).
- a=0xF0, b=0xF0: approx → prod=45056; exact → prod=57600. Also a=0xFF, b=0x03, approx → prod=0 with latency still 6.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after out_valid → prod and out_valid unchanged, in_ready=0.
  - Then out_ready=1 with in_valid=1 → new pair accepted in that same cycle; next out_valid after 6 more cycles.
- Assert rst_n=0 mid-BUSY (3rd row) → immediately out_valid=0, prod=0, in_ready=1. A new pair 0x03×0x05 in exact mode then yields prod=15 after 8 cycles.
- Randomised sweep of 1000 pairs, random approx_en and random out_ready → every result equals the reference kept-term sum, and no result is dropped or duplicated.
